// File: rtl/cpu_io_pkg.sv
// Shared constants for the CPU memory-mapped I/O port: register offsets and
// bit positions inside the STATUS and CONTROL registers.
package cpu_io_pkg;

   localparam logic [1:0] IO_DATA   = 2'd0;
   localparam logic [1:0] IO_STATUS = 2'd1;
   localparam logic [1:0] IO_CTRL   = 2'd2;

   localparam int unsigned ST_TX_EMPTY = 0;
   localparam int unsigned ST_TX_FULL  = 1;
   localparam int unsigned ST_RX_EMPTY = 2;
   localparam int unsigned ST_RX_FULL  = 3;
   localparam int unsigned ST_TX_OVF   = 4;
   localparam int unsigned ST_RX_UNF   = 5;

   localparam int unsigned CTRL_FLUSH_TX  = 0;
   localparam int unsigned CTRL_FLUSH_RX  = 1;
   localparam int unsigned CTRL_CLR_STICK = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; push/pop acceptance is judged on
// occupancy before the edge, and the head reads as zero while empty.
module sync_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  pop,
   input  logic                  flush,
   output logic                  full,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] head
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]       count_q;
   logic                  push_ok, pop_ok;

   assign full    = (count_q == CntW'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty && !flush;
   assign head    = empty ? '0 : mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/cpu_io_port.sv
// Memory-mapped I/O responder: decodes a 4-word window on the CPU bus and
// bridges CPU writes/reads to TX/RX valid/ready streams through two FIFOs.
module cpu_io_port
   import cpu_io_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 8,
   parameter int unsigned           ADDR_WIDTH = 5,
   parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 5'h1C,
   parameter int unsigned           FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sel,
   input  logic                  rd,
   input  logic                  wr,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_oe,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready
);

   logic                  rd_q, wr_q, oe_q, run_q;
   logic                  tx_ovf_q, rx_unf_q;
   logic [DATA_WIDTH-1:0] dout_q, rdata;
   logic                  hit, rd_ev, wr_ev;
   logic [1:0]            offset;
   logic                  ctrl_wr, tx_push, tx_pop, rx_rd, rx_push, rx_pop;
   logic                  tx_full, tx_empty, rx_full, rx_empty;
   logic [DATA_WIDTH-1:0] rx_head;

   assign hit    = sel && (address[ADDR_WIDTH-1:2] == IO_BASE[ADDR_WIDTH-1:2]);
   assign offset = address[1:0];

   // run_q masks the release edge so a strobe held through reset is not seen as new.
   assign wr_ev = run_q && hit && wr && !wr_q;
   assign rd_ev = run_q && hit && rd && !rd_q && !wr_ev;

   assign ctrl_wr = wr_ev && (offset == IO_CTRL);
   assign tx_push = wr_ev && (offset == IO_DATA);
   assign rx_rd   = rd_ev && (offset == IO_DATA);
   assign rx_pop  = rx_rd && !rx_empty;

   assign tx_valid = !tx_empty;
   assign tx_pop   = tx_valid && tx_ready;
   assign rx_ready = run_q && !rx_full;
   assign rx_push  = rx_valid && rx_ready;

   assign data_out = dout_q;
   assign data_oe  = oe_q;

   sync_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (tx_push),
      .din  (data_in),
      .pop  (tx_pop),
      .flush(ctrl_wr && data_in[CTRL_FLUSH_TX]),
      .full (tx_full),
      .empty(tx_empty),
      .head (tx_data)
   );

   sync_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (rx_push),
      .din  (rx_data),
      .pop  (rx_pop),
      .flush(ctrl_wr && data_in[CTRL_FLUSH_RX]),
      .full (rx_full),
      .empty(rx_empty),
      .head (rx_head)
   );

   always_comb begin
      rdata = '0;
      unique case (offset)
         IO_DATA: rdata = rx_head;
         IO_STATUS: begin
            rdata[ST_TX_EMPTY] = tx_empty;
            rdata[ST_TX_FULL]  = tx_full;
            rdata[ST_RX_EMPTY] = rx_empty;
            rdata[ST_RX_FULL]  = rx_full;
            rdata[ST_TX_OVF]   = tx_ovf_q;
            rdata[ST_RX_UNF]   = rx_unf_q;
         end
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         oe_q     <= 1'b0;
         run_q    <= 1'b0;
         tx_ovf_q <= 1'b0;
         rx_unf_q <= 1'b0;
         dout_q   <= '0;
      end else begin
         rd_q  <= rd;
         wr_q  <= wr;
         run_q <= 1'b1;
         oe_q  <= rd_ev || (oe_q && hit && rd);
         if (rd_ev) dout_q <= rdata;
         // Set beats clear when both land on the same edge.
         tx_ovf_q <= (tx_ovf_q && !(ctrl_wr && data_in[CTRL_CLR_STICK])) || (tx_push && tx_full);
         rx_unf_q <= (rx_unf_q && !(ctrl_wr && data_in[CTRL_CLR_STICK])) || (rx_rd && rx_empty);
      end
   end

endmodule

// File: tb/tb_cpu_io_port.sv
// Directed bench for cpu_io_port with hand-computed expected values.
module tb_cpu_io_port;

   logic       clk = 1'b0;
   logic       rst, sel, rd, wr;
   logic [4:0] address;
   logic [7:0] data_in, data_out, tx_data, rx_data;
   logic       data_oe, tx_valid, tx_ready, rx_valid, rx_ready;
   logic [7:0] val;
   logic [7:0] tx_exp [4];

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [4:0] BASE = 5'h1C;

   always #5 clk = ~clk;

   cpu_io_port #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(5),
      .IO_BASE   (5'h1C),
      .FIFO_DEPTH(4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sel     (sel),
      .rd      (rd),
      .wr      (wr),
      .address (address),
      .data_in (data_in),
      .data_out(data_out),
      .data_oe (data_oe),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_read(input logic [1:0] off, output logic [7:0] v);
      sel = 1'b1; address = {BASE[4:2], off}; rd = 1'b1;
      tick();
      v = data_out;
      rd = 1'b0; sel = 1'b0;
      tick();
   endtask

   task automatic cpu_write(input logic [1:0] off, input logic [7:0] d);
      sel = 1'b1; address = {BASE[4:2], off}; data_in = d; wr = 1'b1;
      tick();
      wr = 1'b0; sel = 1'b0;
      tick();
   endtask

   task automatic rx_offer(input logic [7:0] d);
      rx_valid = 1'b1; rx_data = d;
      tick();
      rx_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; sel = 1'b0; rd = 1'b0; wr = 1'b0; address = '0; data_in = '0;
      tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
      tx_exp[0] = 8'hA1; tx_exp[1] = 8'hB2; tx_exp[2] = 8'hC3; tx_exp[3] = 8'hD4;
      repeat (3) tick();
      check_eq("rst_rx_ready", rx_ready, 0);
      check_eq("rst_data_out", data_out, 0);
      check_eq("rst_data_oe", data_oe, 0);
      check_eq("rst_tx_valid", tx_valid, 0);
      check_eq("rst_tx_data", tx_data, 0);
      rst = 1'b0;
      tick();
      check_eq("rel_rx_ready", rx_ready, 1);

      // STATUS after reset, with oe checked across the strobe
      sel = 1'b1; address = BASE + 5'd1; rd = 1'b1;
      tick();
      check_eq("status_reset", data_out, 8'h05);
      check_eq("status_oe_on", data_oe, 1);
      rd = 1'b0; sel = 1'b0;
      tick();
      check_eq("status_oe_off", data_oe, 0);

      // TX overflow with sink stalled
      cpu_write(2'd0, 8'hA1);
      check_eq("tx_valid_first", tx_valid, 1);
      check_eq("tx_data_first", tx_data, 8'hA1);
      cpu_write(2'd0, 8'hB2);
      cpu_write(2'd0, 8'hC3);
      cpu_write(2'd0, 8'hD4);
      cpu_write(2'd0, 8'hE5);
      cpu_read(2'd1, val);
      check_eq("status_tx_full_ovf", val, 8'h16);
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq("tx_drain_data", tx_data, tx_exp[i]);
         check_eq("tx_drain_valid", tx_valid, 1);
         tick();
      end
      check_eq("tx_drained", tx_valid, 0);
      tx_ready = 1'b0;

      // RX underflow and sticky clear
      rx_offer(8'h11);
      rx_offer(8'h22);
      cpu_read(2'd0, val);
      check_eq("rx_pop1", val, 8'h11);
      cpu_read(2'd0, val);
      check_eq("rx_pop2", val, 8'h22);
      cpu_read(2'd0, val);
      check_eq("rx_pop_empty", val, 8'h00);
      cpu_read(2'd1, val);
      check_eq("status_unf_ovf", val, 8'h35);
      cpu_write(2'd2, 8'h04);
      cpu_read(2'd1, val);
      check_eq("status_cleared", val, 8'h05);

      // Held rd yields a single pop
      rx_offer(8'h33);
      rx_offer(8'h44);
      sel = 1'b1; address = BASE; rd = 1'b1;
      repeat (3) tick();
      check_eq("hold_rd_data", data_out, 8'h33);
      check_eq("hold_rd_oe", data_oe, 1);
      rd = 1'b0; sel = 1'b0;
      tick();
      check_eq("hold_rd_oe_drop", data_oe, 0);
      cpu_read(2'd0, val);
      check_eq("hold_rd_second", val, 8'h44);

      // RX full: pop and push on the same edge rejects the push
      for (int i = 0; i < 4; i++) rx_offer(8'h51 + 8'(i));
      check_eq("rx_full_ready", rx_ready, 0);
      rx_valid = 1'b1; rx_data = 8'h99;
      sel = 1'b1; address = BASE; rd = 1'b1;
      tick();
      check_eq("full_pop_data", data_out, 8'h51);
      check_eq("full_pop_ready", rx_ready, 1);
      tick();
      rx_valid = 1'b0;
      check_eq("late_accept_full", rx_ready, 0);
      rd = 1'b0; sel = 1'b0;
      tick();
      cpu_read(2'd0, val);
      check_eq("rx_seq_52", val, 8'h52);
      cpu_read(2'd0, val);
      check_eq("rx_seq_53", val, 8'h53);
      cpu_read(2'd0, val);
      check_eq("rx_seq_54", val, 8'h54);
      cpu_read(2'd0, val);
      check_eq("rx_seq_99", val, 8'h99);

      // rd and wr rising together: write wins
      sel = 1'b1; address = BASE; data_in = 8'h5A; rd = 1'b1; wr = 1'b1;
      tick();
      check_eq("ww_oe", data_oe, 0);
      rd = 1'b0; wr = 1'b0; sel = 1'b0;
      tick();
      check_eq("ww_tx_data", tx_data, 8'h5A);
      cpu_read(2'd1, val);
      check_eq("ww_status", val, 8'h04);

      // Reset during a held DATA read
      rx_offer(8'h77);
      rx_offer(8'h88);
      sel = 1'b1; address = BASE; rd = 1'b1;
      tick();
      check_eq("pre_rst_pop", data_out, 8'h77);
      rst = 1'b1;
      repeat (2) tick();
      check_eq("mid_rst_oe", data_oe, 0);
      rst = 1'b0;
      repeat (2) tick();
      check_eq("post_rst_oe", data_oe, 0);
      check_eq("post_rst_dout", data_out, 8'h00);
      rd = 1'b0; sel = 1'b0;
      tick();
      cpu_read(2'd1, val);
      check_eq("post_rst_status", val, 8'h05);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
